// File: rtl/alu_sequencer.sv
// Initiator side of the 32-bit ALU: decodes one instruction, drives the ALU for
// one cycle, then returns the captured result, trap and branch status.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [15:0]      imm16,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_oper,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf_trap,
  output logic             branch_taken,
  output logic             illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic             r_req_ready, r_resp_valid;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_result;
  logic [2:0]       r_alu_oper;
  logic             r_zero, r_carry, r_ovf, r_branch, r_illegal;
  logic             r_ovf_en, r_beq, r_bne;

  logic [2:0]       w_oper;
  logic             w_use_imm, w_sext, w_illegal, w_ovf_en, w_beq, w_bne;
  logic [WIDTH-1:0] w_b;

  always_comb begin
    w_oper    = 3'b000;
    w_use_imm = 1'b0;
    w_sext    = 1'b0;
    w_illegal = 1'b0;
    w_ovf_en  = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100100: w_oper = 3'b000;
          6'b100101: w_oper = 3'b001;
          6'b100000: begin w_oper = 3'b010; w_ovf_en = 1'b1; end
          6'b100001: w_oper = 3'b010;
          6'b100010: begin w_oper = 3'b110; w_ovf_en = 1'b1; end
          6'b100011: w_oper = 3'b110;
          6'b101010: w_oper = 3'b111;
          default:   w_illegal = 1'b1;
        endcase
      end
      6'b001000: begin w_oper = 3'b010; w_use_imm = 1'b1; w_sext = 1'b1; w_ovf_en = 1'b1; end
      6'b001001, 6'b100011, 6'b101011: begin
        w_oper = 3'b010; w_use_imm = 1'b1; w_sext = 1'b1;
      end
      6'b001010: begin w_oper = 3'b111; w_use_imm = 1'b1; w_sext = 1'b1; end
      6'b001100: begin w_oper = 3'b000; w_use_imm = 1'b1; end
      6'b001101: begin w_oper = 3'b001; w_use_imm = 1'b1; end
      6'b000100: begin w_oper = 3'b110; w_beq = 1'b1; end
      6'b000101: begin w_oper = 3'b110; w_bne = 1'b1; end
      default:   w_illegal = 1'b1;
    endcase
  end

  assign w_b = !w_use_imm ? rt_val :
               w_sext     ? {{(WIDTH-16){imm16[15]}}, imm16} :
                            {{(WIDTH-16){1'b0}}, imm16};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_oper   <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_carry      <= 1'b0;
      r_ovf        <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
      r_ovf_en     <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              // ALU operands are left untouched; respond straight away
              r_illegal    <= 1'b1;
              r_result     <= '0;
              r_zero       <= 1'b0;
              r_carry      <= 1'b0;
              r_ovf        <= 1'b0;
              r_branch     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_alu_a    <= rs_val;
              r_alu_b    <= w_b;
              r_alu_oper <= w_oper;
              r_ovf_en   <= w_ovf_en;
              r_beq      <= w_beq;
              r_bne      <= w_bne;
              r_illegal  <= 1'b0;
              r_state    <= EXEC;
            end
          end
        end
        EXEC: begin
          r_result     <= alu_result;
          r_zero       <= alu_zero;
          r_carry      <= alu_carryout & (r_alu_oper[1:0] == 2'b10);
          r_ovf        <= alu_overflow & r_ovf_en;
          r_branch     <= (r_beq & alu_zero) | (r_bne & ~alu_zero);
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_oper     = r_alu_oper;
  assign result       = r_result;
  assign zero         = r_zero;
  assign carry        = r_carry;
  assign ovf_trap     = r_ovf;
  assign branch_taken = r_branch;
  assign illegal      = r_illegal;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the ALU port, instruction-level
// expected results queued at request time and compared on each response.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic        req_ready, resp_valid;
  logic [5:0]  opcode = '0, funct = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic [15:0] imm16 = '0;
  logic [31:0] alu_a, alu_b, alu_result, result;
  logic [2:0]  alu_oper;
  logic        alu_zero, alu_carryout, alu_overflow;
  logic        zero, carry, ovf_trap, branch_taken, illegal;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .zero(zero),
    .carry(carry), .ovf_trap(ovf_trap), .branch_taken(branch_taken), .illegal(illegal)
  );

  // Ripple-style ALU: B optionally inverted with carry-in, SLT from sign^overflow
  logic [31:0] m_b;
  logic [32:0] m_sum;
  logic        m_ovf;
  always_comb begin
    m_b   = alu_oper[2] ? ~alu_b : alu_b;
    m_sum = {1'b0, alu_a} + {1'b0, m_b} + {32'b0, alu_oper[2]};
    m_ovf = (alu_a[31] == m_b[31]) && (m_sum[31] != alu_a[31]);
    case (alu_oper[1:0])
      2'b00:   alu_result = alu_a & alu_b;
      2'b01:   alu_result = alu_a | alu_b;
      2'b10:   alu_result = m_sum[31:0];
      default: alu_result = {31'b0, m_sum[31] ^ m_ovf};
    endcase
    alu_zero     = (alu_result == 32'b0);
    alu_carryout = m_sum[32];
    alu_overflow = m_ovf;
  end

  typedef struct {
    logic [31:0] a, b, res;
    logic [2:0]  oper;
    logic        z, c, ovf, br, ill;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] last_a = '0, last_b = '0;
  logic [2:0]  last_oper = '0;

  function automatic exp_t calc(input logic [5:0] op, fn, input logic [31:0] rs, rt,
                                input logic [15:0] imm);
    exp_t e;
    int   k;     // 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, -1 illegal
    bit   trap_ok = 0, beq = 0, bne = 0, use_imm = 0, sx = 1;
    logic [32:0] w;
    logic [31:0] b;
    k = -1;
    case (op)
      6'h00: case (fn)
        6'h24: k = 0;
        6'h25: k = 1;
        6'h20: begin k = 2; trap_ok = 1; end
        6'h21: k = 2;
        6'h22: begin k = 3; trap_ok = 1; end
        6'h23: k = 3;
        6'h2a: k = 4;
        default: k = -1;
      endcase
      6'h08: begin k = 2; use_imm = 1; trap_ok = 1; end
      6'h09, 6'h23, 6'h2b: begin k = 2; use_imm = 1; end
      6'h0a: begin k = 4; use_imm = 1; end
      6'h0c: begin k = 0; use_imm = 1; sx = 0; end
      6'h0d: begin k = 1; use_imm = 1; sx = 0; end
      6'h04: begin k = 3; beq = 1; end
      6'h05: begin k = 3; bne = 1; end
      default: k = -1;
    endcase
    b = !use_imm ? rt : (sx ? 32'($signed(imm)) : {16'h0, imm});
    e.c = 0; e.ovf = 0; e.br = 0; e.ill = 0;
    if (k < 0) begin
      e.a = last_a; e.b = last_b; e.oper = last_oper;
      e.res = 0; e.z = 0; e.ill = 1; e.lat = 1;
      return e;
    end
    e.a = rs; e.b = b; e.lat = 2;
    case (k)
      0: begin e.oper = 3'b000; e.res = rs & b; end
      1: begin e.oper = 3'b001; e.res = rs | b; end
      2: begin
        e.oper = 3'b010; w = {1'b0, rs} + {1'b0, b};
        e.res = w[31:0]; e.c = w[32];
        e.ovf = trap_ok && (rs[31] == b[31]) && (w[31] != rs[31]);
      end
      3: begin
        e.oper = 3'b110; w = {1'b0, rs} + {1'b0, ~b} + 33'd1;
        e.res = w[31:0]; e.c = w[32];
        e.ovf = trap_ok && (rs[31] != b[31]) && (w[31] != rs[31]);
      end
      default: begin e.oper = 3'b111; e.res = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0; end
    endcase
    e.z  = (e.res == 0);
    e.br = (beq && e.z) || (bne && !e.z);
    return e;
  endfunction

  // Issue one request, await its response, compare against the scoreboard,
  // optionally stall the consumer for `hold` cycles, then retire it.
  task automatic do_op(input string nm, input logic [5:0] op, fn, input logic [31:0] rs, rt,
                       input logic [15:0] imm, input bit rr_early, input int hold);
    exp_t e, x;
    logic [31:0] s_res;
    logic [5:0]  s_flags;
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready timeout act=%b exp=1", nm, req_ready); end
    e = calc(op, fn, rs, rt, imm);
    sbq.push_back(e);
    last_a = e.a; last_b = e.b; last_oper = e.oper;
    opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm16 = imm;
    req_valid = 1'b1; resp_ready = rr_early;
    @(posedge clk); #1;
    req_valid = 1'b0;
    opcode = 6'($urandom); funct = 6'($urandom); rs_val = $urandom; rt_val = $urandom;
    n = 1;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    x = sbq.pop_front();
    n_checks++;
    if (n !== x.lat) begin n_fail++; $display("FAIL %s latency act=%0d exp=%0d", nm, n, x.lat); end
    n_checks++;
    if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s resp_valid act=%b exp=1", nm, resp_valid); end
    n_checks++;
    if (alu_a !== x.a || alu_b !== x.b || alu_oper !== x.oper) begin
      n_fail++;
      $display("FAIL %s alu_port act=%h/%h/%b exp=%h/%h/%b", nm, alu_a, alu_b, alu_oper, x.a, x.b, x.oper);
    end
    n_checks++;
    if (result !== x.res) begin n_fail++; $display("FAIL %s result act=%h exp=%h", nm, result, x.res); end
    n_checks++;
    if ({zero, carry, ovf_trap, branch_taken, illegal} !== {x.z, x.c, x.ovf, x.br, x.ill}) begin
      n_fail++;
      $display("FAIL %s flags(z,c,ovf,br,ill) act=%b exp=%b", nm,
               {zero, carry, ovf_trap, branch_taken, illegal}, {x.z, x.c, x.ovf, x.br, x.ill});
    end
    s_res = result; s_flags = {zero, carry, ovf_trap, branch_taken, illegal, resp_valid};
    for (int i = 0; i < hold; i++) begin
      opcode = 6'h00; funct = 6'h20; rs_val = $urandom; req_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (result !== s_res || {zero, carry, ovf_trap, branch_taken, illegal, resp_valid} !== s_flags
          || req_ready !== 1'b0 || alu_a !== x.a || alu_oper !== x.oper) begin
        n_fail++;
        $display("FAIL %s hold%0d res=%h flags=%b rdy=%b exp res=%h flags=%b rdy=0", nm, i,
                 result, {zero, carry, ovf_trap, branch_taken, illegal, resp_valid}, req_ready, s_res, s_flags);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s retire resp_valid=%b req_ready=%b exp 0/1", nm, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset handshake req_ready=%b resp_valid=%b exp 0/0", req_ready, resp_valid);
    end
    n_checks++;
    if (alu_a !== 0 || alu_b !== 0 || alu_oper !== 0 || result !== 0 ||
        {zero, carry, ovf_trap, branch_taken, illegal} !== 5'b0) begin
      n_fail++; $display("FAIL reset outputs a=%h b=%h op=%b res=%h flags=%b exp all 0", alu_a, alu_b, alu_oper,
                         result, {zero, carry, ovf_trap, branch_taken, illegal});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset release req_ready act=%b exp=1", req_ready); end
  endtask

  task automatic test_add();
    do_op("add_ovf",  6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 0, 0);
    do_op("addu",     6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0, 0, 0);
    do_op("sub_ovf",  6'h00, 6'h22, 32'h80000000, 32'h1, 16'h0, 0, 0);
    do_op("subu_brw", 6'h00, 6'h23, 32'h1, 32'h2, 16'h0, 0, 0);
    do_op("and",      6'h00, 6'h24, 32'hF0F0FFFF, 32'hFFFF0F0F, 16'h0, 0, 0);
    do_op("or",       6'h00, 6'h25, 32'h0000F000, 32'h0F000000, 16'h0, 0, 0);
    do_op("slt",      6'h00, 6'h2a, 32'h80000000, 32'h7FFFFFFF, 16'h0, 0, 0);
  endtask

  task automatic test_branch();
    do_op("beq", 6'h04, 6'h00, 32'h12345678, 32'h12345678, 16'h0, 0, 0);
    do_op("bne", 6'h05, 6'h00, 32'h12345678, 32'h12345678, 16'h0, 0, 0);
    do_op("bne_ne", 6'h05, 6'h00, 32'h1, 32'h2, 16'h0, 0, 0);
  endtask

  task automatic test_imm();
    do_op("ori",    6'h0d, 6'h00, 32'h0, 32'hDEAD, 16'h8001, 0, 0);
    do_op("slti",   6'h0a, 6'h00, 32'hFFFFFFFF, 32'h5, 16'h0000, 0, 0);
    do_op("andi",   6'h0c, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8421, 0, 0);
    do_op("addi",   6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 16'h0001, 0, 0);
    do_op("lw_neg", 6'h23, 6'h00, 32'h100, 32'h0, 16'hFFF0, 0, 0);
    do_op("sw",     6'h2b, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h0001, 0, 0);
  endtask

  task automatic test_illegal();
    do_op("ill_op",    6'h3f, 6'h00, 32'hAAAA5555, 32'h1, 16'h1234, 0, 5);
    do_op("ill_funct", 6'h00, 6'h3f, 32'h1, 32'h2, 16'h0, 0, 0);
  endtask

  task automatic test_reset_exec();
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    opcode = 6'h00; funct = 6'h22; rs_val = 32'h10; rt_val = 32'h3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || result !== 0 || alu_a !== 0 || alu_b !== 0 ||
        alu_oper !== 0 || {zero, carry, ovf_trap, branch_taken, illegal} !== 5'b0) begin
      n_fail++; $display("FAIL rst_exec outputs vld=%b rdy=%b res=%h a=%h op=%b exp all 0",
                         resp_valid, req_ready, result, alu_a, alu_oper);
    end
    rst = 1'b0;
    last_a = '0; last_b = '0; last_oper = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL rst_exec after%0d resp_valid=%b req_ready=%b exp 0/1", i, resp_valid, req_ready);
      end
    end
    resp_ready = 1'b0;
    do_op("post_rst_sub", 6'h00, 6'h22, 32'h10, 32'h3, 16'h0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h04, 6'h05, 6'h23, 6'h3a};
    logic [5:0] fns[7]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};
    for (int i = 0; i < 24; i++) begin
      logic [31:0] rs = $urandom, rt = $urandom;
      if (i % 4 == 0) rt = rs;
      do_op("b2b", ops[$urandom_range(0, 11)], fns[$urandom_range(0, 6)], rs, rt, 16'($urandom), 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_imm();
    test_illegal();
    test_reset_exec();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
